// File: rtl/zx_vram_bridge_pkg.sv
// Shared types and defaults for the ZX VRAM bridge.
// CPU/video arbitration over a single-port screen RAM.
package zx_vram_bridge_pkg;

  localparam logic [15:0] VRAM_BASE_DEF = 16'h4000;
  localparam logic [15:0] VRAM_SIZE_DEF = 16'h1B00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_ACK
  } state_t;

  function automatic logic in_window(
    input logic [15:0] off,
    input logic [15:0] size
  );
    return off < size;
  endfunction

endpackage

// File: rtl/zx_vram_bridge.sv
// CPU access bridge into ZX screen RAM with video priority.
// Border colour port register included.
module zx_vram_bridge
  import zx_vram_bridge_pkg::*;
#(
  parameter logic [15:0] VRAM_BASE = VRAM_BASE_DEF,
  parameter logic [15:0] VRAM_SIZE = VRAM_SIZE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vid_lock,
  input  logic [12:0] video_addr,
  output logic [7:0]  video_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_busy,
  input  logic        io_we,
  input  logic [15:0] io_addr,
  input  logic [7:0]  io_wdata,
  output logic [2:0]  border,
  output logic [12:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  state_t      r_state;
  logic        r_we;
  logic [7:0]  r_wdata;
  logic [12:0] r_off;
  logic        r_ack;
  logic [7:0]  r_rdata;
  logic        r_lock_d;
  logic [7:0]  r_vdata;
  logic [2:0]  r_border;

  logic [15:0] w_off;
  logic        w_hit;
  logic        w_grant;
  logic        w_unused;

  assign w_off    = cpu_addr - VRAM_BASE;
  assign w_hit    = in_window(w_off, VRAM_SIZE);
  assign w_grant  = (r_state == ST_WAIT) && !vid_lock;
  assign w_unused = ^{io_addr[15:1], io_wdata[7:3]};

  assign mem_addr  = vid_lock ? video_addr : r_off;
  // Gate with rst so an abandoned write never lands.
  assign mem_we    = w_grant & r_we & ~rst;
  assign mem_wdata = r_wdata;

  assign cpu_ack    = r_ack;
  assign cpu_rdata  = r_rdata;
  assign cpu_busy   = (r_state != ST_IDLE);
  assign video_data = r_vdata;
  assign border     = r_border;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
      r_rdata <= 8'hFF;
      r_we    <= 1'b0;
      r_wdata <= 8'h00;
      r_off   <= 13'h0;
    end else begin
      r_ack <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (cpu_req) begin
            r_we    <= cpu_we;
            r_wdata <= cpu_wdata;
            r_off   <= w_off[12:0];
            if (w_hit) begin
              r_state <= ST_WAIT;
            end else begin
              r_state <= ST_ACK;
              r_ack   <= 1'b1;
              r_rdata <= 8'hFF;
            end
          end
        end
        ST_WAIT: begin
          if (!vid_lock) begin
            if (r_we) begin
              r_state <= ST_ACK;
              r_ack   <= 1'b1;
            end else begin
              r_state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          r_rdata <= mem_rdata;
          r_state <= ST_ACK;
          r_ack   <= 1'b1;
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_d <= 1'b0;
      r_vdata  <= 8'h00;
    end else begin
      r_lock_d <= vid_lock;
      if (r_lock_d) begin
        r_vdata <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_border <= 3'b000;
    end else if (io_we && !io_addr[0]) begin
      r_border <= io_wdata[2:0];
    end
  end

endmodule

// File: tb/tb_zx_vram_bridge.sv
// Randomized bench for zx_vram_bridge against a
// transaction-level latency and memory model.
module tb_zx_vram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        vid_lock;
  logic [12:0] video_addr;
  logic [7:0]  video_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        cpu_busy;
  logic        io_we;
  logic [15:0] io_addr;
  logic [7:0]  io_wdata;
  logic [2:0]  border;
  logic [12:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic        tb_we;
  logic [12:0] tb_addr;
  logic [7:0]  tb_data;

  logic [7:0]  ram [8192];
  logic [7:0]  exp_mem [8192];
  logic [7:0]  exp_rdata;
  logic [2:0]  exp_border;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tb_we) ram[tb_addr] <= tb_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  zx_vram_bridge dut (
    .clk(clk), .rst(rst),
    .vid_lock(vid_lock), .video_addr(video_addr),
    .video_data(video_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cpu_busy(cpu_busy),
    .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .border(border),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One CPU access; io_en drives a port write in the strobe cycle.
  task automatic xact(input logic [15:0] a, input logic we,
                      input logic [7:0] wd, input int lk,
                      input bit noise, input bit io_en,
                      input logic [15:0] io_a,
                      input logic [7:0] io_d);
    logic [15:0] off;
    logic [12:0] ix;
    logic [12:0] we_addr;
    logic [7:0]  we_data;
    logic [7:0]  ack_data;
    bit          inw;
    int          e_cyc;
    int          ack_cyc;
    int          acks;
    int          wes;
    int          we_cyc;
    off = a - 16'h4000;
    ix = off[12:0];
    inw = off < 16'h1B00;
    e_cyc = !inw ? 1 : (we ? 2 + lk : 3 + lk);
    ack_cyc = -1; acks = 0; wes = 0; we_cyc = -1;
    we_addr = '0; we_data = '0; ack_data = '0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a;
    cpu_wdata = wd; vid_lock = 1'b0;
    io_we = io_en; io_addr = io_a; io_wdata = io_d;
    if (io_en && !io_a[0]) exp_border = io_d[2:0];
    #2;
    chk("busy_c0", 32'(cpu_busy), 32'd0);
    for (int k = 1; k <= e_cyc + 2; k++) begin
      @(negedge clk);
      vid_lock = (k <= lk);
      video_addr = 13'($urandom);
      if (noise && k <= e_cyc) begin
        cpu_req = 1'($urandom); cpu_we = 1'($urandom);
        cpu_addr = 16'($urandom_range(16'h3F00, 16'h5C00));
        cpu_wdata = 8'($urandom);
        io_we = 1'($urandom); io_addr = 16'($urandom);
        io_wdata = 8'($urandom);
        if (io_we && !io_addr[0]) exp_border = io_wdata[2:0];
      end else begin
        cpu_req = 1'b0; io_we = 1'b0;
      end
      #2;
      if (mem_we) begin
        wes++; we_cyc = k; we_addr = mem_addr; we_data = mem_wdata;
        chk("we_under_lock", 32'(vid_lock), 32'd0);
      end
      if (cpu_ack) begin
        acks++;
        if (ack_cyc < 0) begin ack_cyc = k; ack_data = cpu_rdata; end
      end
      chk("busy", 32'(cpu_busy), 32'(k <= e_cyc));
    end
    vid_lock = 1'b0;
    chk("ack_cycle", 32'(ack_cyc), 32'(e_cyc));
    chk("ack_count", 32'(acks), 32'd1);
    if (inw && we) begin
      chk("we_count", 32'(wes), 32'd1);
      chk("we_cycle", 32'(we_cyc), 32'(1 + lk));
      chk("we_addr", 32'(we_addr), 32'(ix));
      chk("we_data", 32'(we_data), 32'(wd));
      exp_mem[ix] = wd;
    end else begin
      chk("we_count", 32'(wes), 32'd0);
    end
    if (!inw) exp_rdata = 8'hFF;
    else if (!we) exp_rdata = exp_mem[ix];
    if (!we || !inw) chk("ack_rdata", 32'(ack_data), 32'(exp_rdata));
    chk("rdata_held", 32'(cpu_rdata), 32'(exp_rdata));
    chk("border", 32'(border), 32'(exp_border));
    if (inw) chk("ram", 32'(ram[ix]), 32'(exp_mem[ix]));
  endtask

  initial begin
    int acks;
    rst = 1'b1; vid_lock = 1'b0; video_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    io_we = 1'b0; io_addr = '0; io_wdata = '0;
    tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    exp_rdata = 8'hFF; exp_border = 3'b000;
    for (int i = 0; i < 8192; i++) begin
      @(negedge clk);
      tb_we = 1'b1; tb_addr = 13'(i); tb_data = 8'($urandom);
      exp_mem[i] = tb_data;
    end
    @(negedge clk);
    tb_we = 1'b0;
    #2;
    chk("rst_ack", 32'(cpu_ack), 32'd0);
    chk("rst_rdata", 32'(cpu_rdata), 32'hFF);
    chk("rst_vdata", 32'(video_data), 32'd0);
    chk("rst_border", 32'(border), 32'd0);
    chk("rst_busy", 32'(cpu_busy), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    xact(16'h4000, 1'b1, 8'hA5, 0, 0, 0, 16'h0, 8'h0);
    xact(16'h4000, 1'b0, 8'h00, 0, 0, 0, 16'h0, 8'h0);
    xact(16'h5AFF, 1'b1, 8'h3C, 10, 0, 0, 16'h0, 8'h0);
    xact(16'h5B00, 1'b0, 8'h00, 0, 0, 0, 16'h0, 8'h0);
    xact(16'h3FFF, 1'b0, 8'h00, 0, 0, 0, 16'h0, 8'h0);
    xact(16'h0000, 1'b1, 8'h77, 0, 0, 0, 16'h0, 8'h0);
    chk("ram0_kept", 32'(ram[0]), 32'(exp_mem[0]));
    xact(16'h4000, 1'b0, 8'h00, 2, 0, 1, 16'h00FE, 8'h05);
    chk("border_fe", 32'(border), 32'd5);

    @(negedge clk);
    io_we = 1'b1; io_addr = 16'h00FF; io_wdata = 8'h02;
    @(negedge clk);
    io_we = 1'b0;
    #2;
    chk("border_odd", 32'(border), 32'd5);

    xact(16'h5800, 1'b1, 8'h47, 0, 0, 0, 16'h0, 8'h0);
    @(negedge clk);
    vid_lock = 1'b1; video_addr = 13'h1800;
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("video_2cyc", 32'(video_data), 32'h47);
    @(negedge clk);
    vid_lock = 1'b0; video_addr = 13'h0000;
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("video_held", 32'(video_data), 32'h47);

    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 16'h4100; cpu_wdata = 8'hE1;
    @(negedge clk);
    cpu_req = 1'b0; vid_lock = 1'b1;
    @(negedge clk);
    vid_lock = 1'b0; rst = 1'b1;
    #2;
    chk("rst_wait_we", 32'(mem_we), 32'd0);
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rst = 1'b0;
      #2;
      if (cpu_ack) acks++;
      if (k == 0) chk("rst_wait_busy", 32'(cpu_busy), 32'd0);
    end
    chk("rst_wait_acks", 32'(acks), 32'd0);
    chk("rst_wait_ram", 32'(ram[13'h100]), 32'(exp_mem[13'h100]));
    exp_rdata = 8'hFF; exp_border = 3'b000;
    chk("rst_wait_border", 32'(border), 32'd0);
    xact(16'h4100, 1'b0, 8'h00, 1, 0, 0, 16'h0, 8'h0);

    for (int t = 0; t < 80; t++) begin
      logic [15:0] a;
      if ($urandom_range(0, 9) < 7)
        a = 16'($urandom_range(16'h4000, 16'h5AFF));
      else
        a = 16'($urandom);
      xact(a, 1'($urandom), 8'($urandom),
           int'($urandom_range(0, 4)), 1, 0, 16'h0, 8'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/zx_vram_bridge.md
ZX_VRAM_BRIDGE -- requirements
Module: zx_vram_bridge

Interface
REQ-001 Parameters, one per line: VRAM_BASE, 16'h4000, CPU address of the first screen byte.
REQ-002 VRAM_SIZE, 16'h1B00, screen window length in bytes (6144 bitmap + 768 attributes).
REQ-003 clk  in  1  system clock (25 MHz pixel clock); all logic on rising edge.
REQ-004 rst  in  1  synchronous reset, active high.
REQ-005 vid_lock  in  1  video generator owns the memory this cycle.
REQ-006 video_addr  in  13  video generator read address.
REQ-007 video_data  out  8  registered read data returned to the video generator.
REQ-008 cpu_req  in  1  single-cycle request strobe.
REQ-009 cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req.
REQ-010 cpu_addr  in  16  CPU address; cpu_wdata  in  8  CPU write data.
REQ-011 cpu_ack  out  1  one-cycle completion pulse; cpu_rdata  out  8  read data, valid while cpu_ack=1 and held afterwards.
REQ-012 cpu_busy  out  1  high in every state other than IDLE.
REQ-013 io_we  in  1  port-write strobe; io_addr  in  16; io_wdata  in  8.
REQ-014 border  out  3  border colour register.
REQ-015 mem_addr  out  13; mem_we  out  1; mem_wdata  out  8; mem_rdata  in  8. Single-port RAM; read data is valid in the cycle after the address is presented.

Function
REQ-016 FSM states: IDLE, WAIT, READ, ACK.
REQ-017 IDLE: on cpu_req, latch cpu_we, cpu_wdata and off = cpu_addr - VRAM_BASE (16-bit). If VRAM_BASE <= cpu_addr < VRAM_BASE+VRAM_SIZE, go to WAIT. Otherwise go to ACK with cpu_rdata <= 8'hFF; a write outside the window is discarded.
REQ-018 cpu_req is sampled only in IDLE; strobes arriving in WAIT, READ or ACK are ignored and are not queued.
REQ-019 WAIT with vid_lock=1: remain in WAIT with mem_we=0, regardless of how long the lock lasts.
REQ-020 WAIT with vid_lock=0: drive mem_addr=off[12:0]. For a write, assert mem_we=1 and mem_wdata=latched data, then go to ACK. For a read, go to READ.
REQ-021 READ: cpu_rdata <= mem_rdata, then go to ACK; vid_lock has no effect on this capture.
REQ-022 ACK: cpu_ack=1 for exactly this cycle, then go to IDLE.
REQ-023 Minimum latencies with vid_lock=0 (strobe at cycle 0): write ack at cycle 2, RAM written at the cycle-1 edge; read ack at cycle 3; out-of-window ack at cycle 1.
REQ-024 mem_addr mux (combinational): video_addr when vid_lock=1, otherwise off[12:0]. mem_we is never asserted while vid_lock=1.
REQ-025 Video read path: register lock_d <= vid_lock. When lock_d=1, video_data <= mem_rdata; otherwise video_data holds its value. Latency is 2 cycles from the address edge to video_data.
REQ-026 Border port: when io_we=1 and io_addr[0]=0, border <= io_wdata[2:0] at that edge; odd port addresses are ignored. A border write is independent of the FSM and may coincide with any CPU access.
REQ-027 Offset arithmetic is 16-bit unsigned; only off[12:0] reaches the memory, and in-window offsets are always below 13'h1B00.

Reset
REQ-028 rst=1 forces state=IDLE, cpu_ack=0, cpu_rdata=8'hFF, video_data=0, border=0, lock_d=0, mem_we=0.
REQ-029 Reset asserted mid-transaction abandons the access: no ack is ever issued for it and no memory write occurs in the reset cycle.

Structure
REQ-030 A shared package holds the FSM state enumeration and the VRAM_BASE/VRAM_SIZE defaults.
REQ-031 The block is a single module with no sub-modules; the RAM is external.

Verification
REQ-032 vid_lock=0, write 8'hA5 to 16'h4000 -> mem_we=1 with mem_addr=0 at cycle 1, cpu_ack at cycle 2; a following read of 16'h4000 -> cpu_ack at cycle 3 with cpu_rdata=8'hA5.
REQ-033 vid_lock held high for 10 cycles during a write to 16'h5AFF -> no mem_we during the lock, mem_we with mem_addr=13'h1AFF in the first unlocked cycle, ack one cycle later.
REQ-034 Read 16'h5B00 and read 16'h3FFF -> cpu_ack at cycle 1 with cpu_rdata=8'hFF, no memory access; write 16'h0000 -> memory contents unchanged.
REQ-035 vid_lock=1 with video_addr=13'h1800 while RAM[13'h1800]=8'h47 -> video_data=8'h47 two cycles after the address edge, and held after the lock drops.
REQ-036 io_we to port 16'h00FE with data 8'h05 -> border=3'b101; io_we to port 16'h00FF -> border unchanged; a border write in the same cycle as cpu_req -> both complete.
REQ-037 rst pulse while in WAIT -> IDLE next cycle, no cpu_ack, no mem_we; a new request afterwards completes normally.
